// File: rtl/uart_pkt_pkg.sv
// Shared constants and enumerations for the UART packet framing stage.
package uart_pkt_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CSUM,
        EMIT
    } state_t;

    // Error names carry a prefix so they cannot collide with the state literals.
    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_BAD_LEN  = 3'd1,
        ERR_BAD_CSUM = 3'd2,
        ERR_TIMEOUT  = 3'd3,
        ERR_OVERRUN  = 3'd4
    } err_t;

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: MAX_LEN x 8 register array, synchronous write, combinational read.
module uart_pkt_buf #(
    parameter int MAX_LEN = 16,
    parameter int IDX_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [7:0]       wr_data,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [7:0]       rd_data
);

    localparam int AW = $clog2(MAX_LEN);

    logic [7:0] mem [MAX_LEN];

    // Index width covers MAX_LEN itself, so out-of-range addresses are fenced off.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < MAX_LEN)) begin
            mem[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = (32'(rd_addr) < MAX_LEN) ? mem[rd_addr[AW-1:0]] : 8'h00;

endmodule

// File: rtl/uart_pkt_rx.sv
// Packet framer: SYNC, LEN, payload, XOR checksum; payload is released on a
// valid/ready stream only after the checksum matches.
module uart_pkt_rx
    import uart_pkt_pkg::*;
#(
    parameter int MAX_LEN    = 16,
    parameter bit IDLE_ABORT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_available,
    input  logic        rx_idle,
    output logic [7:0]  pkt_data,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic        pkt_last,
    output logic [7:0]  pkt_len,
    output logic        pkt_err,
    output logic [2:0]  err_code,
    output logic [15:0] good_count
);

    localparam int IDX_W = $clog2(MAX_LEN + 1);

    state_t           state, state_n;
    logic [7:0]       len_q, len_n;
    logic [7:0]       csum, csum_n;
    logic [IDX_W-1:0] wr_idx, wr_idx_n;
    logic [IDX_W-1:0] rd_idx, rd_idx_n;
    logic [15:0]      good_n;
    logic             err_fire;
    err_t             err_sel;
    logic             err_q;
    err_t             code_q;
    logic             buf_we;
    logic [7:0]       buf_rd;
    logic             last_beat;
    logic             timeout;

    uart_pkt_buf #(
        .MAX_LEN(MAX_LEN),
        .IDX_W  (IDX_W)
    ) u_buf (
        .clk    (clk),
        .wr_en  (buf_we),
        .wr_addr(wr_idx),
        .wr_data(rx_data),
        .rd_addr(rd_idx),
        .rd_data(buf_rd)
    );

    assign last_beat = (8'(rd_idx) == (len_q - 8'd1));
    // A byte arriving in the same cycle takes priority over the idle abort.
    assign timeout   = IDLE_ABORT && rx_idle && !rx_available;

    always_comb begin
        state_n  = state;
        len_n    = len_q;
        csum_n   = csum;
        wr_idx_n = wr_idx;
        rd_idx_n = rd_idx;
        good_n   = good_count;
        err_fire = 1'b0;
        err_sel  = ERR_NONE;
        buf_we   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_available && (rx_data == SYNC_BYTE)) begin
                    state_n = LEN;
                end
            end
            LEN: begin
                if (rx_available) begin
                    if ((rx_data != 8'd0) && (rx_data <= 8'(MAX_LEN))) begin
                        len_n    = rx_data;
                        csum_n   = rx_data;
                        wr_idx_n = '0;
                        state_n  = PAYLOAD;
                    end else begin
                        err_fire = 1'b1;
                        err_sel  = ERR_BAD_LEN;
                        state_n  = IDLE;
                    end
                end else if (timeout) begin
                    err_fire = 1'b1;
                    err_sel  = ERR_TIMEOUT;
                    state_n  = IDLE;
                end
            end
            PAYLOAD: begin
                if (rx_available) begin
                    buf_we   = 1'b1;
                    csum_n   = csum ^ rx_data;
                    wr_idx_n = wr_idx + 1'b1;
                    if (8'(wr_idx) == (len_q - 8'd1)) begin
                        state_n = CSUM;
                    end
                end else if (timeout) begin
                    err_fire = 1'b1;
                    err_sel  = ERR_TIMEOUT;
                    state_n  = IDLE;
                end
            end
            CSUM: begin
                if (rx_available) begin
                    if (rx_data == csum) begin
                        rd_idx_n = '0;
                        state_n  = EMIT;
                    end else begin
                        err_fire = 1'b1;
                        err_sel  = ERR_BAD_CSUM;
                        state_n  = IDLE;
                    end
                end else if (timeout) begin
                    err_fire = 1'b1;
                    err_sel  = ERR_TIMEOUT;
                    state_n  = IDLE;
                end
            end
            EMIT: begin
                // No backpressure reaches the UART, so a byte here is simply lost.
                if (rx_available) begin
                    err_fire = 1'b1;
                    err_sel  = ERR_OVERRUN;
                end
                if (pkt_ready) begin
                    rd_idx_n = rd_idx + 1'b1;
                    if (last_beat) begin
                        good_n  = good_count + 16'd1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            len_q      <= 8'd0;
            csum       <= 8'd0;
            wr_idx     <= '0;
            rd_idx     <= '0;
            good_count <= 16'd0;
            err_q      <= 1'b0;
            code_q     <= ERR_NONE;
        end else begin
            state      <= state_n;
            len_q      <= len_n;
            csum       <= csum_n;
            wr_idx     <= wr_idx_n;
            rd_idx     <= rd_idx_n;
            good_count <= good_n;
            err_q      <= err_fire;
            if (err_fire) begin
                code_q <= err_sel;
            end
        end
    end

    assign pkt_valid = (state == EMIT);
    assign pkt_data  = buf_rd;
    assign pkt_last  = (state == EMIT) && last_beat;
    assign pkt_len   = len_q;
    assign pkt_err   = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Directed bench for uart_pkt_rx: per-cycle vector table plus hand sequences
// for the maximum-length frame and a reset in the middle of a payload.
module tb_uart_pkt_rx;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_available;
    logic        rx_idle;
    logic [7:0]  pkt_data;
    logic        pkt_valid;
    logic        pkt_ready;
    logic        pkt_last;
    logic [7:0]  pkt_len;
    logic        pkt_err;
    logic [2:0]  err_code;
    logic [15:0] good_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  data;
        logic        avail;
        logic        idle;
        logic        ready;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic        exp_last;
        logic        exp_err;
        logic [2:0]  exp_code;
        logic [15:0] exp_good;
        logic [7:0]  exp_len;
    } vec_t;

    vec_t vecs[$];

    uart_pkt_rx #(
        .MAX_LEN   (16),
        .IDLE_ABORT(1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_available(rx_available),
        .rx_idle     (rx_idle),
        .pkt_data    (pkt_data),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .pkt_last    (pkt_last),
        .pkt_len     (pkt_len),
        .pkt_err     (pkt_err),
        .err_code    (err_code),
        .good_count  (good_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the test completed");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mk(int d, int a, int i, int r, int ev, int ed, int el,
                                int ee, int ec, int eg, int ln);
        vec_t v;
        v.data      = d[7:0];
        v.avail     = a[0];
        v.idle      = i[0];
        v.ready     = r[0];
        v.exp_valid = ev[0];
        v.exp_data  = ed[7:0];
        v.exp_last  = el[0];
        v.exp_err   = ee[0];
        v.exp_code  = ec[2:0];
        v.exp_good  = eg[15:0];
        v.exp_len   = ln[7:0];
        return v;
    endfunction

    // Drive one cycle of inputs at the falling edge, leaving time to sample.
    task automatic applyStimulus(int d, int a, int i, int r);
        @(negedge clk);
        rx_data      = d[7:0];
        rx_available = a[0];
        rx_idle      = i[0];
        pkt_ready    = r[0];
        #1;
    endtask

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic checkRow(string tag, vec_t v);
        checkOutput({tag, ".valid"}, 32'(pkt_valid), 32'(v.exp_valid));
        if (v.exp_valid) begin
            checkOutput({tag, ".data"}, 32'(pkt_data), 32'(v.exp_data));
            checkOutput({tag, ".last"}, 32'(pkt_last), 32'(v.exp_last));
        end
        checkOutput({tag, ".err"},  32'(pkt_err),    32'(v.exp_err));
        checkOutput({tag, ".code"}, 32'(err_code),   32'(v.exp_code));
        checkOutput({tag, ".good"}, 32'(good_count), 32'(v.exp_good));
        checkOutput({tag, ".len"},  32'(pkt_len),    32'(v.exp_len));
    endtask

    initial begin
        logic [7:0] pl [16];
        logic [7:0] sum;

        reset        = 1'b1;
        rx_data      = 8'h00;
        rx_available = 1'b0;
        rx_idle      = 1'b0;
        pkt_ready    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Columns: data avail idle ready | valid data last err code good len
        // Good frame A5 03 11 22 33 03
        vecs.push_back(mk('hA5,1,0,1, 0,0,0,     0,0,0,0));
        vecs.push_back(mk('h03,1,0,1, 0,0,0,     0,0,0,0));
        vecs.push_back(mk('h11,1,0,1, 0,0,0,     0,0,0,3));
        vecs.push_back(mk('h22,1,0,1, 0,0,0,     0,0,0,3));
        vecs.push_back(mk('h33,1,0,1, 0,0,0,     0,0,0,3));
        vecs.push_back(mk('h03,1,0,1, 0,0,0,     0,0,0,3));
        vecs.push_back(mk('h00,0,0,1, 1,'h11,0,  0,0,0,3));
        vecs.push_back(mk('h00,0,0,1, 1,'h22,0,  0,0,0,3));
        vecs.push_back(mk('h00,0,0,1, 1,'h33,1,  0,0,0,3));
        vecs.push_back(mk('h00,0,0,1, 0,0,0,     0,0,1,3));
        // Same frame with ready toggling
        vecs.push_back(mk('hA5,1,0,1, 0,0,0,     0,0,1,3));
        vecs.push_back(mk('h03,1,0,1, 0,0,0,     0,0,1,3));
        vecs.push_back(mk('h11,1,0,1, 0,0,0,     0,0,1,3));
        vecs.push_back(mk('h22,1,0,1, 0,0,0,     0,0,1,3));
        vecs.push_back(mk('h33,1,0,1, 0,0,0,     0,0,1,3));
        vecs.push_back(mk('h03,1,0,1, 0,0,0,     0,0,1,3));
        vecs.push_back(mk('h00,0,0,0, 1,'h11,0,  0,0,1,3));
        vecs.push_back(mk('h00,0,0,1, 1,'h11,0,  0,0,1,3));
        vecs.push_back(mk('h00,0,0,0, 1,'h22,0,  0,0,1,3));
        vecs.push_back(mk('h00,0,0,1, 1,'h22,0,  0,0,1,3));
        vecs.push_back(mk('h00,0,0,0, 1,'h33,1,  0,0,1,3));
        vecs.push_back(mk('h00,0,0,1, 1,'h33,1,  0,0,1,3));
        vecs.push_back(mk('h00,0,0,1, 0,0,0,     0,0,2,3));
        // Bad checksum A5 02 AA 55 00 (true checksum FD)
        vecs.push_back(mk('hA5,1,0,1, 0,0,0,     0,0,2,3));
        vecs.push_back(mk('h02,1,0,1, 0,0,0,     0,0,2,3));
        vecs.push_back(mk('hAA,1,0,1, 0,0,0,     0,0,2,2));
        vecs.push_back(mk('h55,1,0,1, 0,0,0,     0,0,2,2));
        vecs.push_back(mk('h00,1,0,1, 0,0,0,     0,0,2,2));
        vecs.push_back(mk('h00,0,0,1, 0,0,0,     1,2,2,2));
        vecs.push_back(mk('h00,0,0,1, 0,0,0,     0,2,2,2));
        // Bad length 0, then MAX_LEN+1, then good frame A5 01 7E 7F
        vecs.push_back(mk('hA5,1,0,1, 0,0,0,     0,2,2,2));
        vecs.push_back(mk('h00,1,0,1, 0,0,0,     0,2,2,2));
        vecs.push_back(mk('h00,0,0,1, 0,0,0,     1,1,2,2));
        vecs.push_back(mk('hA5,1,0,1, 0,0,0,     0,1,2,2));
        vecs.push_back(mk('h11,1,0,1, 0,0,0,     0,1,2,2));
        vecs.push_back(mk('h00,0,0,1, 0,0,0,     1,1,2,2));
        vecs.push_back(mk('hA5,1,0,1, 0,0,0,     0,1,2,2));
        vecs.push_back(mk('h01,1,0,1, 0,0,0,     0,1,2,2));
        vecs.push_back(mk('h7E,1,0,1, 0,0,0,     0,1,2,1));
        vecs.push_back(mk('h7F,1,0,1, 0,0,0,     0,1,2,1));
        vecs.push_back(mk('h00,0,0,1, 1,'h7E,1,  0,1,2,1));
        vecs.push_back(mk('h00,0,0,1, 0,0,0,     0,1,3,1));
        // Garbage ignored, then timeout inside the payload
        vecs.push_back(mk('h00,1,0,1, 0,0,0,     0,1,3,1));
        vecs.push_back(mk('hFF,1,0,1, 0,0,0,     0,1,3,1));
        vecs.push_back(mk('hA5,1,0,1, 0,0,0,     0,1,3,1));
        vecs.push_back(mk('h02,1,0,1, 0,0,0,     0,1,3,1));
        vecs.push_back(mk('h10,1,0,1, 0,0,0,     0,1,3,2));
        vecs.push_back(mk('h00,0,1,1, 0,0,0,     0,1,3,2));
        vecs.push_back(mk('h00,0,1,1, 0,0,0,     1,3,3,2));
        vecs.push_back(mk('h00,0,0,1, 0,0,0,     0,3,3,2));
        // Bytes arriving while idle is high are processed, not aborted
        vecs.push_back(mk('hA5,1,1,1, 0,0,0,     0,3,3,2));
        vecs.push_back(mk('h01,1,1,1, 0,0,0,     0,3,3,2));
        vecs.push_back(mk('h7E,1,1,1, 0,0,0,     0,3,3,1));
        vecs.push_back(mk('h7F,1,1,1, 0,0,0,     0,3,3,1));
        vecs.push_back(mk('h00,0,1,1, 1,'h7E,1,  0,3,3,1));
        vecs.push_back(mk('h00,0,0,1, 0,0,0,     0,3,4,1));
        // Overrun during a stalled emit, then a SYNC lost on the final beat
        vecs.push_back(mk('hA5,1,0,1, 0,0,0,     0,3,4,1));
        vecs.push_back(mk('h02,1,0,1, 0,0,0,     0,3,4,1));
        vecs.push_back(mk('hC3,1,0,1, 0,0,0,     0,3,4,2));
        vecs.push_back(mk('h3C,1,0,1, 0,0,0,     0,3,4,2));
        vecs.push_back(mk('hFD,1,0,1, 0,0,0,     0,3,4,2));
        vecs.push_back(mk('h55,1,0,0, 1,'hC3,0,  0,3,4,2));
        vecs.push_back(mk('h00,0,0,0, 1,'hC3,0,  1,4,4,2));
        vecs.push_back(mk('h00,0,0,1, 1,'hC3,0,  0,4,4,2));
        vecs.push_back(mk('hA5,1,0,1, 1,'h3C,1,  0,4,4,2));
        vecs.push_back(mk('h00,0,0,1, 0,0,0,     1,4,5,2));
        vecs.push_back(mk('h00,0,0,1, 0,0,0,     0,4,5,2));

        foreach (vecs[i]) begin
            applyStimulus(32'(vecs[i].data), 32'(vecs[i].avail),
                          32'(vecs[i].idle), 32'(vecs[i].ready));
            checkRow($sformatf("row%0d", i), vecs[i]);
        end

        // Maximum-length frame: LEN = 16
        sum = 8'h10;
        for (int i = 0; i < 16; i++) begin
            pl[i] = 8'(i * 7 + 3);
            sum   = sum ^ pl[i];
        end
        applyStimulus('hA5, 1, 0, 1);
        applyStimulus('h10, 1, 0, 1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(32'(pl[i]), 1, 0, 1);
        end
        applyStimulus(32'(sum), 1, 0, 1);
        checkOutput("maxlen.len", 32'(pkt_len), 32'd16);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 0, 1);
            checkOutput($sformatf("maxlen.valid%0d", i), 32'(pkt_valid), 32'd1);
            checkOutput($sformatf("maxlen.data%0d", i), 32'(pkt_data), 32'(pl[i]));
            checkOutput($sformatf("maxlen.last%0d", i), 32'(pkt_last), (i == 15) ? 32'd1 : 32'd0);
        end
        applyStimulus(0, 0, 0, 1);
        checkOutput("maxlen.done_valid", 32'(pkt_valid), 32'd0);
        checkOutput("maxlen.good", 32'(good_count), 32'd6);
        checkOutput("maxlen.err", 32'(pkt_err), 32'd0);

        // Reset asserted in the middle of a payload
        applyStimulus('hA5, 1, 0, 1);
        applyStimulus('h03, 1, 0, 1);
        applyStimulus('h11, 1, 0, 1);
        applyStimulus('h22, 1, 0, 1);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 1);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 1);
        checkOutput("rst.valid", 32'(pkt_valid), 32'd0);
        checkOutput("rst.last", 32'(pkt_last), 32'd0);
        checkOutput("rst.err", 32'(pkt_err), 32'd0);
        checkOutput("rst.code", 32'(err_code), 32'd0);
        checkOutput("rst.good", 32'(good_count), 32'd0);
        checkOutput("rst.len", 32'(pkt_len), 32'd0);
        applyStimulus('hA5, 1, 0, 1);
        applyStimulus('h01, 1, 0, 1);
        applyStimulus('h7E, 1, 0, 1);
        applyStimulus('h7F, 1, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("post_rst.valid", 32'(pkt_valid), 32'd1);
        checkOutput("post_rst.data", 32'(pkt_data), 32'h7E);
        checkOutput("post_rst.last", 32'(pkt_last), 32'd1);
        checkOutput("post_rst.err", 32'(pkt_err), 32'd0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("post_rst.good", 32'(good_count), 32'd1);
        checkOutput("post_rst.valid_drop", 32'(pkt_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
